vga_stream_gen: RTL and testbench
=================================

VGA_STREAM_GEN -- requirements
Module: vga_stream_gen

Interface
REQ-001 Parameter H_VIS, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_VIS, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10; V_SYNC, default 2; V_BP, default 33; vertical porches and sync in lines.
REQ-007 clk  input  1  system clock; single clock domain.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 pix_en  input  1  pixel tick; the generator advances one pixel per cycle with pix_en=1 (tie high for a 25 MHz clk).
REQ-010 bg_rgb  input  3  background colour {R,G,B}, inserted during active video.
REQ-011 vga_str_o  output  26  VGA stream: [25]R [24]G [23]B [22:13]XC [12:3]YC [2]HS [1]VS [0]Active.
REQ-012 frame_start  output  1  one-cycle pulse when the stream presents XC=0, YC=0.
REQ-013 line_start  output  1  one-cycle pulse when the stream presents XC=0 on any line.

Function
REQ-014 Horizontal counter hc SHALL count 0..H_TOT-1, with H_TOT=H_VIS+H_FP+H_SYNC+H_BP (800), advancing only when pix_en=1.
REQ-015 hc at H_TOT-1 with pix_en=1 SHALL wrap to 0 and advance vc by one in the same cycle.
REQ-016 Vertical counter vc SHALL count 0..V_TOT-1, with V_TOT=V_VIS+V_FP+V_SYNC+V_BP (525), wrapping to 0 when hc and vc are both at their maximum.
REQ-017 With pix_en=0, counters and all stream fields SHALL hold; frame_start and line_start SHALL be 0.
REQ-018 Active SHALL be 1 iff hc<H_VIS and vc<V_VIS.
REQ-019 HS SHALL be 0 (active-low) iff H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC (656..751), else 1.
REQ-020 VS SHALL be 0 (active-low) iff V_VIS+V_FP <= vc < V_VIS+V_FP+V_SYNC (490..491), else 1.
REQ-021 XC and YC SHALL carry hc and vc unmodified, 10 bits each, including during blanking.
REQ-022 R,G,B SHALL equal bg_rgb when Active=1 and SHALL be 0 when Active=0.
REQ-023 All stream bits SHALL come from one register stage; every field describes the same (hc,vc), with a latency of one pix_en cycle from the counter state.
REQ-024 frame_start and line_start SHALL be registered and aligned to the stream word they mark.
REQ-025 A bg_rgb change SHALL take effect on the next stream word, with no glitch on the other fields.

Reset
REQ-026 rst_n low SHALL asynchronously clear hc and vc to 0 and frame_start and line_start to 0.
REQ-027 During reset, vga_str_o SHALL be XC=0, YC=0, HS=1, VS=1, Active=0, RGB=0.
REQ-028 After rst_n is released, the first pix_en cycle SHALL present (0,0) with Active=1 and frame_start=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame; after release the next frame SHALL restart cleanly at (0,0) with no partial sync pulse.

Structure
REQ-030 Package vga_stream_pkg SHALL hold the stream width (26), bit-field index constants (ACT, VS, HS, YC, XC, B, G, R) and the default 640x480 timing constants.
REQ-031 The stream consumers and vga_stream_gen SHALL both import vga_stream_pkg.
REQ-032 One sub-module, vga_timing_cnt, SHALL hold the hc/vc counters and wrap logic; field decode and the output register SHALL live in vga_stream_gen.

Verification
REQ-033 Reset release, pix_en=1, bg_rgb=3'b101: first word is XC=0, YC=0, Active=1, R=1, G=0, B=1, HS=1, VS=1, frame_start=1.
REQ-034 Run one line: HS=0 for exactly 96 words (XC 656..751); Active=0 for XC 640..799; line_start repeats every 800 words.
REQ-035 Run one frame: VS=0 for exactly 1600 words (YC 490..491); frame_start repeats every 420000 words; YC never exceeds 524.
REQ-036 Toggle pix_en 1/0 on alternate cycles: the stream advances every second cycle; the frame period is 840000 cycles; the stream holds while pix_en=0.
REQ-037 Assert rst_n low at XC=700, YC=300: the stream goes to its reset value immediately; after release, the frame restarts at (0,0) with frame_start=1.
REQ-038 Change bg_rgb from 3'b111 to 3'b010 at XC=100: words from XC=101 onward carry RGB=010; blanking words carry RGB=000.

Source files
------------

// File: rtl/vga_stream_pkg.sv
// ============================================================================
// Module      : vga_stream_pkg
// Description : Shared stream layout, field indices and 640x480 timing defaults
// Revision    : 1.0
// ============================================================================
`default_nettype none

package vga_stream_pkg;

  localparam int STR_W   = 26;
  localparam int COORD_W = 10;

  // Bit positions inside the stream word; XC and YC are the LSB of 10-bit fields
  localparam int ACT = 0;
  localparam int VS  = 1;
  localparam int HS  = 2;
  localparam int YC  = 3;
  localparam int XC  = 13;
  localparam int B   = 23;
  localparam int G   = 24;
  localparam int R   = 25;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [STR_W-1:0]   vga_word_t;

  function automatic vga_word_t pack_word(
    input logic [2:0] rgb,
    input coord_t     xc,
    input coord_t     yc,
    input logic       hs_n,
    input logic       vs_n,
    input logic       act
  );
    vga_word_t w;
    w                = '0;
    w[R]             = rgb[2];
    w[G]             = rgb[1];
    w[B]             = rgb[0];
    w[XC +: COORD_W] = xc;
    w[YC +: COORD_W] = yc;
    w[HS]            = hs_n;
    w[VS]            = vs_n;
    w[ACT]           = act;
    return w;
  endfunction

  // Idle word: origin coordinates, both syncs inactive (high), blanked
  localparam vga_word_t STR_RESET = pack_word(3'b000, '0, '0, 1'b1, 1'b1, 1'b0);

endpackage

`default_nettype wire

// File: rtl/vga_stream_if.sv
// ============================================================================
// Module      : vga_stream_if
// Description : VGA stream word plus frame/line markers, producer and consumer views
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface vga_stream_if;
  import vga_stream_pkg::*;

  logic [STR_W-1:0] vga_str_o;
  logic             frame_start;
  logic             line_start;

  modport master (
    output vga_str_o,
    output frame_start,
    output line_start
  );

  modport slave (
    input vga_str_o,
    input frame_start,
    input line_start
  );

endinterface

`default_nettype wire

// File: rtl/vga_timing_cnt.sv
// ============================================================================
// Module      : vga_timing_cnt
// Description : Horizontal/vertical raster counters advancing on the pixel tick
// Revision    : 1.0
// ============================================================================
`default_nettype none

module vga_timing_cnt
  import vga_stream_pkg::*;
#(
  parameter int H_TOT = 800,
  parameter int V_TOT = 525
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic pix_en,
  output coord_t    hc,
  output coord_t    vc
);

  localparam coord_t H_MAX = coord_t'(H_TOT - 1);
  localparam coord_t V_MAX = coord_t'(V_TOT - 1);

  coord_t hc_q, hc_d;
  coord_t vc_q, vc_d;

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en) begin
      if (hc_q == H_MAX) begin
        hc_d = '0;
        vc_d = (vc_q == V_MAX) ? '0 : vc_q + coord_t'(1);
      end else begin
        hc_d = hc_q + coord_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hc = hc_q;
  assign vc = vc_q;

endmodule

`default_nettype wire

// File: rtl/vga_stream_gen.sv
// ============================================================================
// Module      : vga_stream_gen
// Description : VGA timing stream generator with registered fields and markers
// Revision    : 1.0
// ============================================================================
`default_nettype none

module vga_stream_gen
  import vga_stream_pkg::*;
#(
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       pix_en,
  input  wire logic [2:0] bg_rgb,
  vga_stream_if.master    str
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam coord_t H_VIS_C  = coord_t'(H_VIS);
  localparam coord_t V_VIS_C  = coord_t'(V_VIS);
  localparam coord_t HS_BEG_C = coord_t'(H_VIS + H_FP);
  localparam coord_t HS_END_C = coord_t'(H_VIS + H_FP + H_SYNC);
  localparam coord_t VS_BEG_C = coord_t'(V_VIS + V_FP);
  localparam coord_t VS_END_C = coord_t'(V_VIS + V_FP + V_SYNC);

  coord_t     hc;
  coord_t     vc;
  logic       active;
  logic       hs_n;
  logic       vs_n;
  logic [2:0] rgb;

  vga_word_t  str_q, str_d;
  logic       frame_start_q, frame_start_d;
  logic       line_start_q, line_start_d;

  vga_timing_cnt #(
    .H_TOT (H_TOT),
    .V_TOT (V_TOT)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .hc     (hc),
    .vc     (vc)
  );

  // Every field is decoded from the same (hc,vc) and captured in one register,
  // so the word is self-consistent and bg_rgb lands on the next word only.
  always_comb begin
    active        = (hc < H_VIS_C) && (vc < V_VIS_C);
    hs_n          = !((hc >= HS_BEG_C) && (hc < HS_END_C));
    vs_n          = !((vc >= VS_BEG_C) && (vc < VS_END_C));
    rgb           = active ? bg_rgb : 3'b000;

    str_d         = str_q;
    frame_start_d = 1'b0;
    line_start_d  = 1'b0;
    if (pix_en) begin
      str_d         = pack_word(rgb, hc, vc, hs_n, vs_n, active);
      frame_start_d = (hc == '0) && (vc == '0);
      line_start_d  = (hc == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      str_q         <= STR_RESET;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      str_q         <= str_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  assign str.vga_str_o   = str_q;
  assign str.frame_start = frame_start_q;
  assign str.line_start  = line_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_stream_gen.sv
// ============================================================================
// Module      : tb_vga_stream_gen
// Description : Scoreboard bench for vga_stream_gen on a scaled-down raster
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_vga_stream_gen;

  // Scaled raster keeps full-frame runs short: 160 x 40 = 6400 words per frame
  localparam int H_VIS  = 120;
  localparam int H_FP   = 8;
  localparam int H_SYNC = 16;
  localparam int H_BP   = 16;
  localparam int V_VIS  = 30;
  localparam int V_FP   = 3;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 5;
  localparam int H_TOT  = 160;
  localparam int V_TOT  = 40;
  localparam int F_TOT  = H_TOT * V_TOT;

  localparam logic [25:0] RESET_WORD = {3'b000, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0};

  typedef struct packed {
    logic [25:0] w;
    logic        fs;
    logic        ls;
  } exp_t;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       pix_en = 1'b0;
  logic [2:0] bg_rgb = 3'b101;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          mhc   = 0;
  int          mvc   = 0;
  int          last_x = 0;
  int          last_y = 0;
  logic [25:0] last_exp = RESET_WORD;

  vga_stream_if sif();

  vga_stream_gen #(
    .H_VIS  (H_VIS),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_VIS  (V_VIS),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .bg_rgb (bg_rgb),
    .str    (sif)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] exp_word(input int x, input int y, input logic [2:0] rgb);
    logic       act;
    logic       hs_n;
    logic       vs_n;
    logic [9:0] xc;
    logic [9:0] yc;
    act  = (x < H_VIS) && (y < V_VIS);
    hs_n = !((x >= H_VIS + H_FP) && (x < H_VIS + H_FP + H_SYNC));
    vs_n = !((y >= V_VIS + V_FP) && (y < V_VIS + V_FP + V_SYNC));
    xc   = x[9:0];
    yc   = y[9:0];
    return {(act ? rgb : 3'b000), xc, yc, hs_n, vs_n, act};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: push the expected word when a pixel tick is driven, compare after the edge
  task automatic tick(input logic pe);
    exp_t e;
    pix_en = pe;
    if (pe) begin
      e.w  = exp_word(mhc, mvc, bg_rgb);
      e.fs = (mhc == 0) && (mvc == 0);
      e.ls = (mhc == 0);
      sb.push_back(e);
      last_x = mhc;
      last_y = mvc;
      if (mhc == H_TOT - 1) begin
        mhc = 0;
        mvc = (mvc == V_TOT - 1) ? 0 : mvc + 1;
      end else begin
        mhc++;
      end
    end
    @(posedge clk);
    #1;
    if (pe) begin
      e = sb.pop_front();
      last_exp = e.w;
      check("word", 32'(sif.vga_str_o), 32'(e.w));
      check("frame_start", 32'(sif.frame_start), 32'(e.fs));
      check("line_start", 32'(sif.line_start), 32'(e.ls));
    end else begin
      check("hold_word", 32'(sif.vga_str_o), 32'(last_exp));
      check("hold_frame_start", 32'(sif.frame_start), 32'd0);
      check("hold_line_start", 32'(sif.line_start), 32'd0);
    end
  endtask

  initial begin
    int          hs_low0;
    int          act0_line0;
    int          ls_cnt;
    int          ls_gap_bad;
    int          last_ls;
    int          vs_low;
    int          max_yc;
    int          fs_cnt;
    int          fs_at;
    int          guard;
    logic [25:0] w;

    hs_low0 = 0; act0_line0 = 0; ls_cnt = 0; ls_gap_bad = 0; last_ls = 0;
    vs_low = 0; max_yc = 0; fs_cnt = 0; fs_at = 0; guard = 0;

    // Held in reset
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_word", 32'(sif.vga_str_o), 32'(RESET_WORD));
      check("reset_frame_start", 32'(sif.frame_start), 32'd0);
      check("reset_line_start", 32'(sif.line_start), 32'd0);
    end

    // First word after release
    #2 rst_n = 1'b1;
    tick(1'b1);
    w = sif.vga_str_o;
    check("first_xc_yc", 32'(w[22:3]), 32'd0);
    check("first_active", 32'(w[0]), 32'd1);
    check("first_rgb", 32'(w[25:23]), 32'd5);
    check("first_hs_vs", 32'(w[2:1]), 32'd3);
    check("first_frame_start", 32'(sif.frame_start), 32'd1);

    // One full frame of continuous pixel ticks
    for (int i = 1; i <= F_TOT; i++) begin
      tick(1'b1);
      w = sif.vga_str_o;
      if (i < H_TOT && w[12:3] == 10'd0) begin
        if (!w[2]) hs_low0++;
        if (!w[0]) act0_line0++;
      end
      if (!w[1]) vs_low++;
      if (int'(w[12:3]) > max_yc) max_yc = int'(w[12:3]);
      if (sif.line_start) begin
        ls_cnt++;
        if (i - last_ls != H_TOT) ls_gap_bad++;
        last_ls = i;
      end
      if (sif.frame_start) begin
        fs_cnt++;
        fs_at = i;
      end
    end
    check("hs_low_words_line0", hs_low0, H_SYNC);
    check("blank_words_line0", act0_line0, H_TOT - H_VIS);
    check("line_start_count", ls_cnt, V_TOT);
    check("line_start_gap_errors", ls_gap_bad, 0);
    check("vs_low_words", vs_low, V_SYNC * H_TOT);
    check("max_yc", max_yc, V_TOT - 1);
    check("frame_start_count", fs_cnt, 1);
    check("frame_period_words", fs_at, F_TOT);

    // Pixel tick on alternate cycles: frame period doubles, stream holds between ticks
    fs_cnt = 0;
    fs_at  = 0;
    for (int c = 1; c <= 2 * F_TOT; c++) begin
      tick(c % 2 == 0);
      if (sif.frame_start) begin
        fs_cnt++;
        fs_at = c;
      end
    end
    check("toggle_frame_start_count", fs_cnt, 1);
    check("toggle_frame_period_cycles", fs_at, 2 * F_TOT);

    // Background colour change while XC=100 is presented
    bg_rgb = 3'b111;
    for (int i = 0; i < 100; i++) tick(1'b1);
    check("bg_change_point_xc", 32'(sif.vga_str_o[22:13]), 32'd100);
    check("bg_old_rgb", 32'(sif.vga_str_o[25:23]), 32'd7);
    bg_rgb = 3'b010;
    tick(1'b1);
    check("bg_new_xc", 32'(sif.vga_str_o[22:13]), 32'd101);
    check("bg_new_rgb", 32'(sif.vga_str_o[25:23]), 32'd2);
    for (int i = 0; i < H_VIS - 101; i++) tick(1'b1);
    check("blank_xc", 32'(sif.vga_str_o[22:13]), H_VIS);
    check("blank_rgb", 32'(sif.vga_str_o[25:23]), 32'd0);

    // Reset in the middle of a horizontal sync pulse
    while (!(last_x == H_VIS + H_FP + 4 && last_y == 20) && guard < F_TOT) begin
      tick(1'b1);
      guard++;
    end
    check("reset_point_reached", guard < F_TOT, 1);
    check("reset_point_hs_low", 32'(sif.vga_str_o[2]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_word", 32'(sif.vga_str_o), 32'(RESET_WORD));
    check("async_reset_frame_start", 32'(sif.frame_start), 32'd0);
    check("async_reset_line_start", 32'(sif.line_start), 32'd0);
    sb.delete();
    mhc      = 0;
    mvc      = 0;
    last_exp = RESET_WORD;
    pix_en   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold_word", 32'(sif.vga_str_o), 32'(RESET_WORD));
    end
    #2 rst_n = 1'b1;
    tick(1'b1);
    check("restart_xc_yc", 32'(sif.vga_str_o[22:3]), 32'd0);
    check("restart_hs", 32'(sif.vga_str_o[2]), 32'd1);
    check("restart_frame_start", 32'(sif.frame_start), 32'd1);
    for (int i = 0; i < 2 * H_TOT; i++) tick(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
